// File: rtl/io_tx_controller.sv
// rtl/io_tx_controller.sv - raster-order image SRAM reader with credit-based output FIFO
module io_tx_controller #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] nrows_i,
  input  logic [7:0] ncols_i,
  output logic [7:0] dout_o,
  output logic       dout_valid_o,
  input  logic       dout_ready_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       sram_sense_en_o,
  output logic       sram_write_en_o,
  output logic [7:0] sram_din_o,
  output logic [7:0] sram_row_o,
  output logic [7:0] sram_col_o,
  input  logic [7:0] sram_dout_i
);

  // One slot per cycle of read latency, one for the head and one spare so
  // that a full-rate stream never stalls on credits.
  localparam int         FIFO_DEPTH = READ_LATENCY + 2;
  localparam logic [3:0] DEPTH_C    = 4'(FIFO_DEPTH);
  localparam int         IDX_W      = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                  state_q;
  logic [7:0]              nrows_q, ncols_q;
  logic [7:0]              row_q, col_q;
  logic                    busy_q, done_q;
  logic [READ_LATENCY-1:0] tok_q, tok_d;
  logic [7:0]              buf_q [FIFO_DEPTH];
  logic [7:0]              buf_d [FIFO_DEPTH];
  logic [3:0]              count_q, count_d;
  logic                    dout_valid_q;
  logic [3:0]              inflight, inflight_d;
  logic                    issue, capture, pop, last_addr;
  logic [IDX_W-1:0]        wr_idx;

  assign last_addr = (row_q == nrows_q) && (col_q == ncols_q);

  // Credit check, latency token pipe and shifting output FIFO next state
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + 4'(tok_q[i]);
    end
    issue   = (state_q == S_READ) && ((count_q + inflight) < DEPTH_C);
    tok_d   = tok_q << 1;
    tok_d[0] = issue;
    inflight_d = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_d = inflight_d + 4'(tok_d[i]);
    end
    capture = tok_q[READ_LATENCY-1];
    pop     = dout_valid_q && dout_ready_i;
    count_d = count_q + 4'(capture) - 4'(pop);
    wr_idx  = IDX_W'(count_q - 4'(pop));
    buf_d   = buf_q;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        buf_d[i] = buf_q[i+1];
      end
      buf_d[FIFO_DEPTH-1] = '0;
    end
    if (capture) begin
      buf_d[wr_idx] = sram_dout_i;
    end
  end

  // Frame sequencing: latch dimensions, walk raster addresses, signal completion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      nrows_q <= '0;
      ncols_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The done cycle is spent in IDLE; a start there is still ignored.
          if (start_i && !done_q) begin
            nrows_q <= nrows_i;
            ncols_q <= ncols_i;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          if (issue) begin
            if (last_addr) begin
              state_q <= S_DRAIN;
            end else if (col_q == ncols_q) begin
              col_q <= '0;
              row_q <= row_q + 8'd1;
            end else begin
              col_q <= col_q + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          // Decided on next-state occupancy so done lands right after the last transfer.
          if (count_d == 4'd0 && inflight_d == 4'd0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read token pipe and output FIFO storage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tok_q        <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      tok_q        <= tok_d;
      count_q      <= count_d;
      dout_valid_q <= (count_d != 4'd0);
      buf_q        <= buf_d;
    end
  end

  assign dout_o          = buf_q[0];
  assign dout_valid_o    = dout_valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign sram_sense_en_o = 1'b1;
  assign sram_write_en_o = 1'b0;
  assign sram_din_o      = 8'h00;
  assign sram_row_o      = row_q;
  assign sram_col_o      = col_q;

endmodule

// File: tb/tb_io_tx_controller.sv
// tb/tb_io_tx_controller.sv - self-checking bench for io_tx_controller
module tb_io_tx_controller;

  logic       clk = 1'b0;
  logic       rst, start, dout_ready;
  logic [7:0] nrows, ncols;
  logic [7:0] dout;
  logic       dout_valid, busy, done;
  logic       sense_en, write_en;
  logic [7:0] sram_din, sram_row, sram_col;
  logic [7:0] sram_dout = 8'h00;

  io_tx_controller dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .nrows_i        (nrows),
    .ncols_i        (ncols),
    .dout_o         (dout),
    .dout_valid_o   (dout_valid),
    .dout_ready_i   (dout_ready),
    .busy_o         (busy),
    .done_o         (done),
    .sram_sense_en_o(sense_en),
    .sram_write_en_o(write_en),
    .sram_din_o     (sram_din),
    .sram_row_o     (sram_row),
    .sram_col_o     (sram_col),
    .sram_dout_i    (sram_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Image content: row*16+col for small frames, perturbed for tall ones
  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 16 + c + (r >> 4));
  endfunction

  // One-cycle-latency SRAM
  always @(posedge clk) sram_dout <= pix(int'(sram_row), int'(sram_col));

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  bit         armed = 0;
  bit         m_busy = 0, m_done = 0, m_after_rst = 0;
  logic [7:0] m_q[$];
  int         m_left = 0, m_xfer = 0, m_nr = 0, m_nc = 0;
  bit         p_stall = 0;
  logic [7:0] p_dout = 8'h00;

  // Event log for literal timing checks
  logic [7:0] rx_q[$];
  int         first_xfer_cyc = -1, done_cyc = -1, busy_rise_cyc = -1;
  int         t0 = 0;

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    bit xfer, nd;
    int idx;
    logic [7:0] e;
    xfer = 0;
    nd   = 0;
    if (armed) begin
      chk(busy == m_busy, "busy", busy, m_busy);
      chk(done == m_done, "done", done, m_done);
      chk(sense_en == 1'b1 && write_en == 1'b0 && sram_din == 8'h00, "sram_ctl",
          {sense_en, write_en}, 2);
      if (m_after_rst) begin
        chk(dout_valid == 1'b0 && dout == 8'h00, "rst_dout", {dout_valid, dout}, 0);
        chk(sram_row == 8'h00 && sram_col == 8'h00, "rst_addr", {sram_row, sram_col}, 0);
      end
      if (p_stall) begin
        chk(dout_valid == 1'b1 && dout == p_dout, "stall_hold", {dout_valid, dout}, {1'b1, p_dout});
      end
      if (m_busy) begin
        idx = int'(sram_row) * (m_nc + 1) + int'(sram_col);
        chk(int'(sram_row) <= m_nr && int'(sram_col) <= m_nc, "addr_range",
            {sram_row, sram_col}, {m_nr[7:0], m_nc[7:0]});
        chk(idx <= m_xfer + 3, "outstanding", idx - m_xfer, 3);
      end
      xfer = dout_valid && dout_ready;
      if (xfer) begin
        if (m_q.size() == 0) begin
          chk(1'b0, "unexpected_byte", dout, -1);
        end else begin
          e = m_q.pop_front();
          chk(dout == e, "byte", dout, e);
        end
        rx_q.push_back(dout);
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        m_xfer++;
        if (m_busy) m_left--;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (busy && busy_rise_cyc < 0) busy_rise_cyc = cyc;
    end
    p_stall = dout_valid && !dout_ready;
    p_dout  = dout;
    if (rst) begin
      armed       = 1;
      m_busy      = 0;
      m_done      = 0;
      m_after_rst = 1;
      p_stall     = 0;
      m_q.delete();
    end else begin
      m_after_rst = 0;
      nd = m_busy && xfer && (m_left == 0);
      if (!m_busy && !m_done && start) begin
        m_nr   = int'(nrows);
        m_nc   = int'(ncols);
        m_left = (m_nr + 1) * (m_nc + 1);
        m_xfer = 0;
        for (int r = 0; r <= m_nr; r++)
          for (int c = 0; c <= m_nc; c++)
            m_q.push_back(pix(r, c));
        m_busy = 1;
      end else if (nd) begin
        m_busy = 0;
      end
      m_done = nd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_log();
    first_xfer_cyc = -1;
    done_cyc       = -1;
    busy_rise_cyc  = -1;
    rx_q.delete();
  endtask

  task automatic start_frame(input int nr, input int nc);
    reset_log();
    nrows = 8'(nr);
    ncols = 8'(nc);
    start = 1'b1;
    t0    = cyc;
    step();
    start = 1'b0;
  endtask

  // mode 0: ready high, 1: random 50%, 2: low for relative cycles 5..12
  task automatic wait_done(input int budget, input int mode, input string name);
    for (int i = 0; i < budget && done_cyc < 0; i++) begin
      case (mode)
        1:       dout_ready = 1'($urandom_range(0, 1));
        2:       dout_ready = !((cyc - t0) >= 5 && (cyc - t0) <= 12);
        default: dout_ready = 1'b1;
      endcase
      step();
    end
    chk(done_cyc >= 0, {name, "_done_seen"}, done_cyc, 1);
    dout_ready = 1'b1;
  endtask

  logic [7:0] exp6 [6] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};
  logic [7:0] exp4 [4] = '{8'h00, 8'h01, 8'h10, 8'h11};

  initial begin
    rst = 1'b1; start = 1'b0; nrows = 8'd0; ncols = 8'd0; dout_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // 2x3 frame at full rate
    start_frame(1, 2);
    wait_done(200, 0, "t1");
    chk(first_xfer_cyc - t0 == 3, "t1_first_byte_cycle", first_xfer_cyc - t0, 3);
    chk(done_cyc - t0 == 9, "t1_done_cycle", done_cyc - t0, 9);
    chk(busy_rise_cyc - t0 == 1, "t1_busy_rise", busy_rise_cyc - t0, 1);
    chk(rx_q.size() == 6, "t1_count", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) chk(rx_q[i] == exp6[i], "t1_byte", rx_q[i], exp6[i]);

    // 1x1 frame
    start_frame(0, 0);
    wait_done(200, 0, "t2");
    chk(first_xfer_cyc - t0 == 3, "t2_first_byte_cycle", first_xfer_cyc - t0, 3);
    chk(done_cyc - t0 == 4, "t2_done_cycle", done_cyc - t0, 4);
    chk(rx_q.size() == 1 && rx_q[0] == 8'h00, "t2_byte", rx_q.size(), 1);

    // 4x4 frame with an 8-cycle stall
    start_frame(3, 3);
    wait_done(200, 2, "t3");
    chk(rx_q.size() == 16, "t3_count", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++)
      chk(rx_q[i] == 8'((i / 4) * 16 + i % 4), "t3_byte", rx_q[i], (i / 4) * 16 + i % 4);
    chk(done_cyc - t0 == 27, "t3_done_cycle", done_cyc - t0, 27);

    // Index-255 boundaries on rows and on columns under random backpressure
    start_frame(255, 63);
    wait_done(40000, 1, "t4a");
    chk(rx_q.size() == 16384, "t4a_count", rx_q.size(), 16384);
    if (rx_q.size() > 0) chk(rx_q[rx_q.size()-1] == 8'h3E, "t4a_last", rx_q[rx_q.size()-1], 8'h3E);
    start_frame(3, 255);
    wait_done(4000, 1, "t4b");
    chk(rx_q.size() == 1024, "t4b_count", rx_q.size(), 1024);
    if (rx_q.size() > 0) chk(rx_q[rx_q.size()-1] == 8'h2F, "t4b_last", rx_q[rx_q.size()-1], 8'h2F);

    // Reset in the middle of a 4x4 frame, then a 2x2 frame
    start_frame(3, 3);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    chk(done_cyc < 0, "t5_no_done", done_cyc, -1);
    chk(busy == 1'b0 && dout_valid == 1'b0, "t5_idle", {busy, dout_valid}, 0);
    start_frame(1, 1);
    wait_done(200, 0, "t5");
    chk(rx_q.size() == 4, "t5_count", rx_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) chk(rx_q[i] == exp4[i], "t5_byte", rx_q[i], exp4[i]);

    // Stray starts in READ, DRAIN and the done cycle; nrows changed mid-frame
    start_frame(2, 2);
    for (int i = 1; i < 200 && done_cyc < 0; i++) begin
      start = (i == 3) || (i == 10) || done;
      nrows = (i >= 3) ? 8'd5 : 8'd2;
      step();
    end
    start = 1'b0;
    chk(done_cyc >= 0, "t6_done_seen", done_cyc, 1);
    chk(done_cyc - t0 == 12, "t6_done_cycle", done_cyc - t0, 12);
    repeat (10) step();
    chk(rx_q.size() == 9, "t6_count", rx_q.size(), 9);
    chk(busy == 1'b0, "t6_stays_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_tx_controller.md
# io_tx_controller

Streams a stored image out of the image SRAM in raster order as a byte stream with a valid/ready handshake. It is the read-side counterpart of the image receive controller and sits between `img_sram_intf` and the output I/O path. A `start` pulse latches the frame dimensions, issues SRAM reads at up to one per cycle, and absorbs SRAM read latency and downstream backpressure in a small internal FIFO. A one-cycle `done` pulse marks the end of each frame.

## Interface
- READ_LATENCY, 1: cycles from address on `sram_img.row/col` to data on `sram_img.dout`; legal values 1..2.
- FIFO_DEPTH, derived, READ_LATENCY+2: internal output buffer entries; not overridable.

- clk  in  1  block clock; same clock as `sram_img.clk`.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- nrows  in  8  last row index (frame height = nrows+1); latched on accepted start.
- ncols  in  8  last column index (frame width = ncols+1); latched on accepted start.
- dout  out  8  pixel byte at FIFO head.
- dout_valid  out  1  dout holds a valid pixel.
- dout_ready  in  1  downstream accepts; transfer = dout_valid && dout_ready.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle end-of-frame pulse.
- sram_img  mst  img_sram_intf  drives sense_en=1, write_en=0, din=0, row, col; reads dout.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: if start, latch nrows/ncols, clear row/col counters to 0, go to READ. Otherwise hold.
- READ issue rule: issue = (fifo_count + inflight) < FIFO_DEPTH. `inflight` counts issued reads whose data is not yet written to the FIFO.
- READ addressing: on issue, present (row, col) and push a valid token into a READ_LATENCY-deep shift register. Advance col; at col==ncols, wrap col to 0 and increment row. Compare before incrementing so that index 255 never overflows.
- When the issued address is (nrows, ncols), go to DRAIN after that cycle. No further issues.
- Capture: when the token emerges from the shift register, write `sram_img.dout` into the FIFO. Capture is never gated; the credit rule guarantees that no overflow occurs.
- Output: dout/dout_valid come from the FIFO head. On a transfer, pop. While dout_valid && !dout_ready, dout holds stable.
- DRAIN: when fifo_count==0 and inflight==0, assert done for one cycle, drop busy in the same cycle, and go to IDLE.
- row/col hold their last value when not issuing. sense_en is constant 1; write_en is constant 0.
- start outside IDLE is ignored, including in the done cycle. nrows/ncols changes mid-frame have no effect.
- Simultaneous push and pop on the FIFO: count is unchanged and ordering is preserved.
- Reset (any state): state=IDLE, counters/row/col=0, shift register cleared, FIFO emptied, dout=0, dout_valid=0, busy=0, done=0 on the next edge. The frame is aborted, in-flight SRAM data is discarded, and no done is issued for the aborted frame.

## Timing
- Cycle 0: start sampled in IDLE. Cycle 1: READ, busy=1, first address driven.
- First dout_valid at cycle 2+READ_LATENCY.
- With dout_ready held high: one byte per cycle, no bubbles. For N=(nrows+1)(ncols+1), the last transfer is at cycle 1+READ_LATENCY+N and done at cycle 2+READ_LATENCY+N.
- Outstanding reads plus FIFO entries never exceed FIFO_DEPTH.
- All outputs are registered. There is no combinational path from dout_ready to sram_img.row/col or to dout_valid.

## Test plan
- 2x3 frame (nrows=1, ncols=2), READ_LATENCY=1, SRAM preloaded with value row*16+col, ready=1 -> bytes 00,01,02,10,11,12 on cycles 3..8; done only at cycle 9; busy cycles 1..8.
- 1x1 frame (nrows=0, ncols=0) -> one byte from (0,0) at cycle 3, done at cycle 4, row/col never leave 0.
- Backpressure: 4x4 frame, dout_ready low for cycles 5..12 -> dout stable while stalled, at most 3 reads outstanding+buffered, all 16 bytes in order, no duplicates.
- Full 256x256 frame, random 50% dout_ready -> 65536 bytes in raster order, last from (255,255), no counter wrap, exactly one done.
- rst asserted at cycle 10 of a 4x4 frame -> all outputs 0 at cycle 11, no late capture, no done; a subsequent start with nrows=ncols=1 yields 4 correct bytes.
- start pulsed during READ, DRAIN, and the done cycle, with nrows changed mid-frame -> ignored; frame length unchanged.
